// File: rtl/bc_col_accum_if.sv
// Handshake bundle between the column compressor stream and the accumulator.
// master: beat producer / result consumer.  slave: the accumulator.
interface bc_col_accum_if #(
    parameter int ACC_W    = 24,
    parameter int MAX_COLS = 16
);
    localparam int CW = $clog2(MAX_COLS) + 1;

    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic             in_last;
    logic [1:0]       in_out;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [CW-1:0]    res_cols;
    logic             res_ovf;
    logic             abort;

    modport master (
        output in_valid, in_first, in_last, in_out, res_ready,
        input  in_ready, res_valid, res_data, res_cols, res_ovf, abort
    );

    modport slave (
        input  in_valid, in_first, in_last, in_out, res_ready,
        output in_ready, res_valid, res_data, res_cols, res_ovf, abort
    );
endinterface

// File: rtl/bc_col_accum.sv
// bc_col_accum: shift-accumulates 2-bit column beats (LSB column first) into
// an ACC_W result, one result per operand group, valid/ready on both sides.
// Optional macro BC_COL_SIGNED_MSB_EN: the in_last beat's contribution is
// subtracted, giving a two's-complement MSB column weight.
module bc_col_accum #(
    parameter int ACC_W    = 24,
    parameter int MAX_COLS = 16
) (
    input  logic              clk,
    input  logic              rstn,
    bc_col_accum_if.slave     bus
);
    localparam int            CW   = $clog2(MAX_COLS) + 1;
    localparam logic [CW-1:0] MAXC = CW'(MAX_COLS);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           r_state, w_state_n;
    logic [ACC_W-1:0] r_acc,   w_acc_n;
    logic [CW-1:0]    r_col,   w_col_n;
    logic             r_ovf,   w_ovf_n;
    logic             r_abort, w_abort_n;

    logic             w_beat;
    logic             w_restart;
    logic             w_drop;
    logic             w_sub;
    logic [CW-1:0]    w_shift;
    logic [ACC_W-1:0] w_c;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_sum;

    assign bus.in_ready  = (r_state != DONE);
    assign bus.res_valid = (r_state == DONE);
    assign bus.res_data  = r_acc;
    assign bus.res_cols  = r_col;
    assign bus.res_ovf   = r_ovf;
    assign bus.abort     = r_abort;

    assign w_beat    = bus.in_valid && (r_state != DONE);
    // Any beat taken in IDLE starts a group, whether or not in_first is set.
    assign w_restart = (r_state == IDLE) || bus.in_first;
    // Columns past MAX_COLS contribute nothing; the counter saturates instead.
    assign w_drop    = !w_restart && (r_col >= MAXC);
    assign w_shift   = w_restart ? '0 : r_col;
    assign w_c       = w_drop ? '0 : (ACC_W'(bus.in_out) << w_shift);
    assign w_base    = w_restart ? '0 : r_acc;

`ifdef BC_COL_SIGNED_MSB_EN
    assign w_sub = bus.in_last;
`else
    assign w_sub = 1'b0;
`endif

    assign w_sum = w_sub ? (w_base - w_c) : (w_base + w_c);

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_col   <= '0;
            r_ovf   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_acc   <= w_acc_n;
            r_col   <= w_col_n;
            r_ovf   <= w_ovf_n;
            r_abort <= w_abort_n;
        end
    end

    // Next-state and next-datapath values.
    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_col_n   = r_col;
        w_ovf_n   = r_ovf;
        w_abort_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    w_acc_n   = w_sum;
                    w_col_n   = CW'(1);
                    w_ovf_n   = 1'b0;
                    w_state_n = bus.in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_beat) begin
                    w_acc_n = w_sum;
                    if (bus.in_first) begin
                        // Mid-group restart: partial sum discarded.
                        w_col_n   = CW'(1);
                        w_ovf_n   = 1'b0;
                        w_abort_n = 1'b1;
                    end else if (w_drop) begin
                        w_ovf_n = 1'b1;
                    end else begin
                        w_col_n = r_col + CW'(1);
                    end
                    if (bus.in_last) w_state_n = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bc_col_accum.sv
// Directed bench for bc_col_accum; expected values hand-computed per build.
module tb_bc_col_accum;
    localparam int ACC_W    = 24;
    localparam int MAX_COLS = 16;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    bc_col_accum_if #(.ACC_W(ACC_W), .MAX_COLS(MAX_COLS)) bus ();

    bc_col_accum #(.ACC_W(ACC_W), .MAX_COLS(MAX_COLS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat; it is taken at the next posedge if in_ready is high.
    task automatic send(input logic [1:0] v, input logic first, input logic last);
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_out   = v;
        bus.in_first = first;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic take();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic [ACC_W-1:0] held;
        n_cmp = 0;
        n_err = 0;
        rstn          = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_out    = 2'd3;
        bus.in_first  = 1'b1;
        bus.in_last   = 1'b1;
        bus.res_ready = 1'b0;

        // 1: reset with in_valid high
        repeat (3) tick();
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        rstn         = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("post_rst_res_data", 32'(bus.res_data), 32'd0);
        chk("post_rst_res_cols", 32'(bus.res_cols), 32'd0);

        // 2: 3,2,1 back-to-back
        send(2'd3, 1'b1, 1'b0);
        send(2'd2, 1'b0, 1'b0);
        chk("t2_valid_early", 32'(bus.res_valid), 32'd0);
        send(2'd1, 1'b0, 1'b1);
        chk("t2_res_valid", 32'(bus.res_valid), 32'd1);
`ifdef BC_COL_SIGNED_MSB_EN
        chk("t2_res_data", 32'(bus.res_data), 32'd3);
`else
        chk("t2_res_data", 32'(bus.res_data), 32'd11);
`endif
        chk("t2_res_cols", 32'(bus.res_cols), 32'd3);
        chk("t2_res_ovf", 32'(bus.res_ovf), 32'd0);

        // 3: hold under backpressure
        held = bus.res_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", 32'(bus.res_valid), 32'd1);
            chk("t3_hold_data", 32'(bus.res_data), 32'(held));
            chk("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        take();
        chk("t3_valid_drop", 32'(bus.res_valid), 32'd0);
        chk("t3_in_ready_back", 32'(bus.in_ready), 32'd1);

        // 4: mid-group restart
        send(2'd1, 1'b1, 1'b0);
        send(2'd1, 1'b0, 1'b0);
        chk("t4_abort_quiet", 32'(bus.abort), 32'd0);
        send(2'd2, 1'b1, 1'b0);
        chk("t4_abort_pulse", 32'(bus.abort), 32'd1);
        send(2'd1, 1'b0, 1'b1);
        chk("t4_abort_clear", 32'(bus.abort), 32'd0);
        chk("t4_res_valid", 32'(bus.res_valid), 32'd1);
`ifdef BC_COL_SIGNED_MSB_EN
        chk("t4_res_data", 32'(bus.res_data), 32'd0);
`else
        chk("t4_res_data", 32'(bus.res_data), 32'd4);
`endif
        chk("t4_res_cols", 32'(bus.res_cols), 32'd2);
        take();

        // 5: overflow, MAX_COLS+2 beats of 1 (dropped last beat adds nothing)
        for (int i = 0; i < MAX_COLS + 2; i++)
            send(2'd1, (i == 0), (i == MAX_COLS + 1));
        chk("t5_res_valid", 32'(bus.res_valid), 32'd1);
        chk("t5_res_ovf", 32'(bus.res_ovf), 32'd1);
        chk("t5_res_cols", 32'(bus.res_cols), 32'(MAX_COLS));
        chk("t5_res_data", 32'(bus.res_data), 32'd65535);
        take();

        // 6: single-column group, then reset mid-group
        send(2'd2, 1'b1, 1'b1);
        chk("t6_res_valid", 32'(bus.res_valid), 32'd1);
`ifdef BC_COL_SIGNED_MSB_EN
        chk("t6_res_data", 32'(bus.res_data), 32'h00FF_FFFE);
`else
        chk("t6_res_data", 32'(bus.res_data), 32'd2);
`endif
        chk("t6_res_cols", 32'(bus.res_cols), 32'd1);
        take();
        send(2'd1, 1'b1, 1'b0);
        rstn = 1'b0;
        send(2'd1, 1'b0, 1'b1);
        rstn = 1'b1;
        chk("t6_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("t6_rst_res_data", 32'(bus.res_data), 32'd0);
        chk("t6_rst_res_cols", 32'(bus.res_cols), 32'd0);
        chk("t6_rst_res_ovf", 32'(bus.res_ovf), 32'd0);
        chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) tick();
        chk("t6_no_result", 32'(bus.res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
